// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch sequencer: owns the fetch PC, drives the ROM address and buffers
// returned words with their PCs in an in-order queue presented to decode via valid/ready.
module instr_fetch_ctrl #(
    parameter int unsigned DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       fetch_en,
    output logic [31:0]                rom_addr,
    input  logic [31:0]                rom_data,
    output logic                       instr_valid,
    input  logic                       instr_ready,
    output logic [31:0]                instr_data,
    output logic [31:0]                instr_pc,
    input  logic                       redirect_valid,
    input  logic [31:0]                redirect_pc,
    output logic [$clog2(DEPTH):0]     q_count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic [31:0]     mem_pc_q   [DEPTH];
    logic [31:0]     mem_data_q [DEPTH];

    logic push, pop;

    assign instr_valid = (count_q != '0);
    assign pop         = instr_valid & instr_ready;
    assign push        = fetch_en & ~redirect_valid & ((count_q < DepthCnt) | pop);

    assign rom_addr   = fetch_pc_q;
    assign q_count    = count_q;
    assign instr_data = instr_valid ? mem_data_q[rd_ptr_q] : 32'h0;
    assign instr_pc   = instr_valid ? mem_pc_q[rd_ptr_q]   : 32'h0;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (redirect_valid) begin
            // A same-cycle pop is dropped along with the rest of the queue.
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (push) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
                wr_ptr_d   = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // Storage needs no reset: head outputs are masked while the queue is empty.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            mem_pc_q[wr_ptr_q]   <= fetch_pc_q;
            mem_data_q[wr_ptr_q] <= rom_data;
        end
    end

endmodule

// File: doc/instr_fetch_ctrl.md
Name: instr_fetch_ctrl

Overview:
- Fetch sequencer between the combinational instruction ROM and the decode stage.
- Owns the fetch PC and drives the ROM address every cycle. Captures each returned word with its PC into a small in-order queue.
- Presents queued instructions to decode over a valid/ready handshake.
- Accepts a redirect (branch/jump) that flushes the queue and restarts fetch at a new PC.

Parameters:
- DEPTH, 2, number of queue entries (power of two, ≥2).
- RESET_PC, 32'h0000_0000, fetch PC loaded on reset (word aligned).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- fetch_en  input  1  1 = fetch allowed; 0 = hold PC, no new pushes (queue still drains).
- rom_addr  output  32  byte address to ROM; equals fetch_pc (combinational from register).
- rom_data  input  32  instruction word returned combinationally by ROM for rom_addr.
- instr_valid  output  1  queue head holds a valid instruction.
- instr_ready  input  1  decode accepts head this cycle.
- instr_data  output  32  instruction word at queue head; 32'h0 when empty.
- instr_pc  output  32  PC of instruction at queue head; 32'h0 when empty.
- redirect_valid  input  1  flush and restart fetch at redirect_pc.
- redirect_pc  input  32  new fetch PC; bits [1:0] forced to 0 internally.
- q_count  output  $clog2(DEPTH)+1  current queue occupancy (debug/verification).

Behaviour:
- Reset (reset=1 at clock edge): fetch_pc=RESET_PC, q_count=0, read/write pointers=0. instr_valid=0, instr_data=0, instr_pc=0 the cycle after. Reset overrides redirect, push and pop in the same cycle.
- pop = instr_valid & instr_ready.
- push = fetch_en & ~redirect_valid & (q_count<DEPTH | pop). Push when full is legal only with a simultaneous pop.
- On push: write entry {fetch_pc, rom_data}, write pointer +1 (wraps mod DEPTH), fetch_pc <= fetch_pc+4. 32-bit wraparound: 32'hFFFF_FFFC+4 = 0.
- On pop: read pointer +1 (wraps mod DEPTH).
- q_count next = q_count + push − pop; never exceeds DEPTH, never underflows.
- Latency:
  - A word fetched in cycle N is visible at the head in cycle N+1 if the queue was empty.
  - Sustained throughput is 1 instr/cycle when instr_ready is held 1.
  - No combinational path from rom_data to instr_data.
- Redirect (redirect_valid=1, not in reset):
  - Next cycle q_count=0 and pointers=0.
  - fetch_pc <= {redirect_pc[31:2],2'b00}.
  - No push that cycle. A pop in the same cycle is discarded: decode must not consume it.
  - instr_valid=0 the cycle after. The first redirected instruction appears 2 cycles after the redirect edge.
  - Back-to-back redirects: the last one wins.
- fetch_en=0: fetch_pc frozen, no push. Pops continue until empty. Re-enabling resumes at the held fetch_pc.
- Head outputs are stable while instr_valid=1 & instr_ready=0. The head entry never changes without a pop or redirect.
- Empty queue: instr_valid=0, instr_ready is ignored, outputs are 32'h0.

Test Plan:
- ROM[0]=32'h0011_0233, ROM[1]=32'h4011_02B3, ready=1, fetch_en=1 after reset → cycle 1 head {pc 0, 0x00110233}; cycle 2 head {pc 4, 0x401102B3}; pc advances by 4 each cycle with no bubbles.
- instr_ready=0 for 5 cycles from reset → q_count reaches 2 (DEPTH) and holds; rom_addr stays at 8; head stays {pc 0}; raising ready drains pcs 0, 4, 8 in order with no loss or duplication.
- Redirect to 32'h0000_0013 while q_count=2 and ready=1 → next cycle instr_valid=0, q_count=0, rom_addr=0x10; following cycle head pc=0x10.
- Redirect and reset asserted together → state equals plain reset (rom_addr=RESET_PC, q_count=0).
- Redirect to 32'hFFFF_FFFC, ready=1 → head pcs 0xFFFFFFFC then 0x00000000.
- fetch_en=0 with 2 queued entries and ready=1 → both pop, instr_valid falls, rom_addr frozen; fetch_en=1 → fetch resumes at the frozen address.
